// File: rtl/rr_arbiter_16_pkg.sv
// rtl/rr_arbiter_16_pkg.sv - shared constants and state encoding for the 16-way round-robin arbiter
package rr_arbiter_16_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/rr_pick_16.sv
// rtl/rr_pick_16.sv - combinational round-robin winner search over 16 requesters
module rr_pick_16
    import rr_arbiter_16_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    logic [NUM_REQ-1:0]   cand;
    logic [NUM_REQ-1:0]   rot;
    logic [2*NUM_REQ-1:0] dbl;
    logic [SEL_W-1:0]     off;

    // Rotating by ptr makes bit 0 the highest-priority slot; the offset wraps back mod 16.
    always_comb begin
        cand  = req & ~mask;
        dbl   = {cand, cand} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        found = |rot;
        off   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = SEL_W'(i);
            end
        end
        idx = ptr + off;
    end

endmodule

// File: rtl/rr_arbiter_16.sv
// rtl/rr_arbiter_16.sv - round-robin arbiter driving the shared 16:1 datapath mux select
module rr_arbiter_16
    import rr_arbiter_16_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 done,
    output logic [NUM_REQ-1:0]   grant,
    output logic [SEL_W-1:0]     sel,
    output logic                 busy,
    output logic                 preempt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);

    state_t             state;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    logic               owner_req;
    logic               timeout;
    logic               rel_now;
    logic               to_rel;
    logic [SEL_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic               found;
    logic [SEL_W-1:0]   idx;

    // On release the search starts just past the owner; only a done-release masks the owner.
    always_comb begin
        owner_req = req[sel];
        timeout   = HOLD_EN && (cnt == HOLD_LAST);
        rel_now   = (state == ST_BUSY) && (done || !owner_req || timeout);
        to_rel    = rel_now && !done && owner_req && timeout;
        pick_ptr  = (state == ST_BUSY) ? sel + 1'b1 : ptr;
        pick_mask = ((state == ST_BUSY) && done) ? grant : '0;
    end

    rr_pick_16 u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (found),
        .idx   (idx)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            grant   <= '0;
            sel     <= '0;
            ptr     <= '0;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    preempt <= 1'b0;
                    if (found) begin
                        grant <= NUM_REQ'(1) << idx;
                        sel   <= idx;
                        cnt   <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (rel_now) begin
                        ptr     <= sel + 1'b1;
                        preempt <= to_rel;
                        cnt     <= '0;
                        if (found) begin
                            grant <= NUM_REQ'(1) << idx;
                            sel   <= idx;
                        end else begin
                            grant <= '0;
                            state <= ST_IDLE;
                        end
                    end else begin
                        preempt <= 1'b0;
                        if (cnt != {CNT_W{1'b1}}) begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_BUSY);

endmodule
